// File: rtl/mul_issue_ctrl_pkg.sv
// mul_issue_ctrl_pkg: shared definitions for the multiplier issue controller.
//   OP_*          RV32M multiply opcode encoding carried on req_op
//   mul_entry_t   in-flight pipeline entry (valid, op, operands); the operand
//                 sign bits are read straight from rs1[31]/rs2[31]
//   mul_fixup()   converts a signed x signed product into the selected result
package mul_issue_ctrl_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } mul_entry_t;

  // The core only multiplies signed x signed. Treating an operand as unsigned
  // adds (other operand << 32) when its sign bit is set, so only the high word
  // needs correcting.
  function automatic logic [31:0] mul_fixup(input logic [1:0]  op,
                                            input logic [63:0] p,
                                            input logic [31:0] rs1,
                                            input logic [31:0] rs2);
    logic [31:0] hi;
    logic [31:0] res;
    hi = p[63:32];
    unique case (op)
      OP_MUL:    res = p[31:0];
      OP_MULH:   res = hi;
      OP_MULHSU: res = hi + (rs2[31] ? rs1 : 32'd0);
      default:   res = hi + (rs1[31] ? rs2 : 32'd0) + (rs2[31] ? rs1 : 32'd0);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: request, core-operand and response signals of the
// multiplier issue controller.
//   master: requester/environment side (drives requests, resp_rdy, mul_p)
//   slave : controller side (drives req_rdy, mul_a/mul_b, responses)
interface mul_issue_ctrl_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req_vld;
  logic             req_rdy;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      mul_p;
  logic             resp_vld;
  logic             resp_rdy;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_vld, req_op, req_rs1, req_rs2, req_tag, resp_rdy, mul_p,
    input  req_rdy, mul_a, mul_b, resp_vld, resp_data, resp_tag
  );

  modport slave (
    input  req_vld, req_op, req_rs1, req_rs2, req_tag, resp_rdy, mul_p,
    output req_rdy, mul_a, mul_b, resp_vld, resp_data, resp_tag
  );
endinterface

// File: rtl/mul_issue_fifo.sv
// mul_issue_fifo: synchronous response FIFO.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       synchronous clear (empties the FIFO)
//   i_wr/i_wdata write strobe and data
//   i_rd        pop (ignored when empty)
//   o_rdata     head entry, stable until popped
//   o_empty     no entries
//   o_count     occupancy
module mul_issue_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [AW:0]   CntOne  = (AW+1)'(1);
  localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_do_rd;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CntFull);
  assign w_do_rd = i_rd && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr)    r_wptr <= r_wptr + PtrOne;
      if (w_do_rd) r_rptr <= r_rptr + PtrOne;
      case ({i_wr, w_do_rd})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr && !i_clr) r_mem[r_wptr] <= i_wdata;
  end

  // Admission control guarantees space; a write into a full FIFO is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_wr && w_full && !i_clr));

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue controller and result sequencer for a fixed-latency
// 32x32 signed multiplier core without stall.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       (only with MUL_ISSUE_CTRL_FLUSH_EN defined) drops all work
//   bus         slave side of mul_issue_ctrl_if: req_* handshake in,
//               mul_a/mul_b/mul_p core interface, resp_* handshake out
//   busy        any operation in flight or buffered
// Requests are admitted only against free response-FIFO credits, so a product
// leaving the core always has a slot waiting for it.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT    = 5,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TAG_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef MUL_ISSUE_CTRL_FLUSH_EN
  input  logic            flush,
`endif
  mul_issue_ctrl_if.slave bus,
  output logic            busy
);
  localparam int unsigned     CntW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned     FifoW     = TAG_W + 32;
  localparam logic [CntW-1:0] CreditMax = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CreditOne = CntW'(1);

  mul_entry_t                    r_pipe [MUL_LAT];
  logic [TAG_W-1:0]              r_tag  [MUL_LAT];
  logic                          r_fix_vld;
  logic [31:0]                   r_fix_data;
  logic [TAG_W-1:0]              r_fix_tag;
  logic [CntW-1:0]               r_credit;
  logic                          r_live;

  logic                          w_flush;
  logic                          w_accept;
  logic                          w_pop;
  logic                          w_any_vld;
  logic                          w_fifo_empty;
  logic [FifoW-1:0]              w_fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0]   w_fifo_count;

`ifdef MUL_ISSUE_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // r_live keeps req_rdy low until the first clock after reset release.
  assign bus.req_rdy = r_live && (r_credit != '0) && !w_flush;
  assign w_accept    = bus.req_vld && bus.req_rdy;
  assign w_pop       = bus.resp_vld && bus.resp_rdy;
  assign bus.mul_a   = w_accept ? bus.req_rs1 : 32'd0;
  assign bus.mul_b   = w_accept ? bus.req_rs2 : 32'd0;

  always_comb begin
    w_any_vld = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) w_any_vld = w_any_vld | r_pipe[i].valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        r_pipe[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_fix_vld  <= 1'b0;
      r_fix_data <= '0;
      r_fix_tag  <= '0;
      r_credit   <= CreditMax;
      r_live     <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_pipe[0] <= '{valid: w_accept, op: bus.req_op, rs1: bus.req_rs1, rs2: bus.req_rs2};
      r_tag[0]  <= bus.req_tag;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
        r_tag[i]  <= r_tag[i-1];
      end
      // The last stage lines up with the core output for its operation.
      r_fix_vld  <= r_pipe[MUL_LAT-1].valid;
      r_fix_data <= mul_fixup(r_pipe[MUL_LAT-1].op, bus.mul_p,
                              r_pipe[MUL_LAT-1].rs1, r_pipe[MUL_LAT-1].rs2);
      r_fix_tag  <= r_tag[MUL_LAT-1];

      if (w_flush) begin
        for (int i = 0; i < MUL_LAT; i++) r_pipe[i].valid <= 1'b0;
        r_fix_vld <= 1'b0;
        r_credit  <= CreditMax;
      end else if (w_accept && !w_pop) begin
        r_credit <= r_credit - CreditOne;
      end else if (!w_accept && w_pop) begin
        r_credit <= r_credit + CreditOne;
      end
    end
  end

  mul_issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FifoW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_flush),
    .i_wr    (r_fix_vld),
    .i_wdata ({r_fix_tag, r_fix_data}),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.resp_vld  = !w_fifo_empty;
  assign bus.resp_data = w_fifo_rdata[31:0];
  assign bus.resp_tag  = w_fifo_rdata[FifoW-1:32];
  assign busy          = w_any_vld || r_fix_vld || (w_fifo_count != '0);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: self-checking bench for mul_issue_ctrl with a behavioural
// MUL_LAT-cycle signed multiplier core and an arithmetic RV32M result model.
module tb_mul_issue_ctrl;
  localparam int MulLat = 5;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
`ifdef MUL_ISSUE_CTRL_FLUSH_EN
  logic flush = 1'b0;
`endif
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  rec_t exp_q[$];
  rec_t got_q[$];
  logic [63:0] core [MulLat];

  mul_issue_ctrl_if #(.TAG_W(4)) bus ();

  mul_issue_ctrl #(
    .MUL_LAT    (MulLat),
    .FIFO_DEPTH (8),
    .TAG_W      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MUL_ISSUE_CTRL_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Core model: no reset, so stale products keep flowing through reset.
  always @(posedge clk) begin
    core[0] <= smul(bus.mul_a, bus.mul_b);
    for (int i = 1; i < MulLat; i++) core[i] <= core[i-1];
  end
  assign bus.mul_p = core[MulLat-1];

  // Architectural RV32M results from full-width arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0:    begin p = 64'(sa * sb); return p[31:0]; end
      2'd1:    begin p = 64'(sa * sb); return p[63:32]; end
      2'd2:    begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      default: begin p = 64'(ua * ub); return p[63:32]; end
    endcase
  endfunction

  // One clock: sample handshakes at the negedge, return 1ns after the posedge.
  task automatic step();
    rec_t r;
    @(negedge clk);
    if (bus.req_vld && bus.req_rdy) begin
      r.data = ref_result(bus.req_op, bus.req_rs1, bus.req_rs2);
      r.tag  = bus.req_tag;
      r.cyc  = cyc;
      exp_q.push_back(r);
    end
    if (bus.resp_vld && bus.resp_rdy) begin
      r.data = bus.resp_data;
      r.tag  = bus.resp_tag;
      r.cyc  = cyc;
      got_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_req();
    bus.req_op  = 2'($urandom_range(0, 3));
    bus.req_rs1 = $urandom;
    bus.req_rs2 = $urandom;
    if ($urandom_range(0, 3) == 0) bus.req_rs1[31] = 1'b1;
    if ($urandom_range(0, 3) == 0) bus.req_rs2[31] = 1'b1;
    bus.req_tag = 4'($urandom);
  endtask

  task automatic drain(input int n, input int budget);
    for (int w = 0; w < budget && got_q.size() < n; w++) step();
  endtask

  task automatic test_reset();
    bus.req_vld = 1'b1;
    bus.req_op = 2'd0;
    bus.req_rs1 = 32'h1234_5678;
    bus.req_rs2 = 32'h9abc_def0;
    bus.req_tag = 4'd1;
    bus.resp_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 5;
    if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_req_rdy: got %b want 0", bus.req_rdy); end
    if (bus.resp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_resp_vld: got %b want 0", bus.resp_vld); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (bus.mul_a !== 32'd0) begin n_fail++; $display("FAIL reset_mul_a: got %h want 0", bus.mul_a); end
    if (bus.mul_b !== 32'd0) begin n_fail++; $display("FAIL reset_mul_b: got %h want 0", bus.mul_b); end
    bus.req_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_rdy: got %b want 1", bus.req_rdy); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op   [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] t_a    [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0001};
    logic [31:0] t_b    [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0001};
    logic [3:0]  t_tag  [4] = '{4'd3, 4'd5, 4'd9, 4'd12};
    logic [31:0] t_want [4] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0002_0001};
    for (int k = 0; k < 4; k++) begin
      exp_q.delete();
      got_q.delete();
      bus.resp_rdy = 1'b1;
      bus.req_vld = 1'b1;
      bus.req_op = t_op[k];
      bus.req_rs1 = t_a[k];
      bus.req_rs2 = t_b[k];
      bus.req_tag = t_tag[k];
      #1;
      n_checks += 2;
      if (bus.mul_a !== t_a[k]) begin n_fail++; $display("FAIL dir%0d_mul_a: got %h want %h", k, bus.mul_a, t_a[k]); end
      if (bus.mul_b !== t_b[k]) begin n_fail++; $display("FAIL dir%0d_mul_b: got %h want %h", k, bus.mul_b, t_b[k]); end
      step();
      bus.req_vld = 1'b0;
      drain(1, 20);
      n_checks++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
        n_fail++;
        $display("FAIL dir%0d_resp: got %0d responses / %0d accepts want 1/1", k, got_q.size(), exp_q.size());
      end else begin
        n_checks += 3;
        if (got_q[0].data !== t_want[k]) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", k, got_q[0].data, t_want[k]); end
        if (got_q[0].tag !== t_tag[k]) begin n_fail++; $display("FAIL dir%0d_tag: got %h want %h", k, got_q[0].tag, t_tag[k]); end
        if (got_q[0].cyc - exp_q[0].cyc != MulLat + 2) begin
          n_fail++;
          $display("FAIL dir%0d_latency: got %0d want %0d", k, got_q[0].cyc - exp_q[0].cyc, MulLat + 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    got_q.delete();
    bus.resp_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rand_req();
      bus.req_vld = 1'b1;
      #1;
      n_checks++;
      if (bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_req_rdy[%0d]: got %b want 1", k, bus.req_rdy); end
      step();
    end
    bus.req_vld = 1'b0;
    drain(16, 40);
    n_checks++;
    if (got_q.size() != 16 || exp_q.size() != 16) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses / %0d accepts want 16/16", got_q.size(), exp_q.size());
    end else begin
      n_checks++;
      if (got_q[0].cyc - exp_q[0].cyc != MulLat + 2) begin
        n_fail++; $display("FAIL b2b_latency: got %0d want %0d", got_q[0].cyc - exp_q[0].cyc, MulLat + 2);
      end
      for (int i = 0; i < 16; i++) begin
        n_checks += 2;
        if (got_q[i].data !== exp_q[i].data || got_q[i].tag !== exp_q[i].tag) begin
          n_fail++;
          $display("FAIL b2b_resp[%0d]: got %h/%h want %h/%h", i, got_q[i].data, got_q[i].tag,
                   exp_q[i].data, exp_q[i].tag);
        end
        if (got_q[i].cyc != got_q[0].cyc + i) begin
          n_fail++; $display("FAIL b2b_spacing[%0d]: got cycle %0d want %0d", i, got_q[i].cyc, got_q[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          n_sent;
    logic [31:0] held;
    exp_q.delete();
    got_q.delete();
    bus.resp_rdy = 1'b0;
    n_sent = 0;
    rand_req();
    bus.req_vld = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (exp_q.size() > n_sent) begin
        n_sent = exp_q.size();
        if (n_sent >= 10) bus.req_vld = 1'b0;
        else rand_req();
      end
    end
    n_checks += 4;
    if (exp_q.size() != 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", exp_q.size()); end
    if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_req_rdy: got %b want 0", bus.req_rdy); end
    if (bus.mul_a !== 32'd0) begin n_fail++; $display("FAIL bp_mul_a: got %h want 0", bus.mul_a); end
    if (bus.resp_vld !== 1'b1) begin n_fail++; $display("FAIL bp_resp_vld: got %b want 1", bus.resp_vld); end
    held = bus.resp_data;
    repeat (3) step();
    n_checks += 2;
    if (bus.resp_data !== held) begin n_fail++; $display("FAIL bp_hold: got %h want %h", bus.resp_data, held); end
    if (exp_q.size() > 0 && bus.resp_data !== exp_q[0].data) begin
      n_fail++; $display("FAIL bp_head: got %h want %h", bus.resp_data, exp_q[0].data);
    end
    bus.req_vld = 1'b0;
    bus.resp_rdy = 1'b1;
    #1;
    n_checks++;
    if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_at_pop: got %b want 0", bus.req_rdy); end
    step();
    n_checks++;
    if (bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_after_pop: got %b want 1", bus.req_rdy); end
    drain(8, 20);
    n_checks++;
    if (got_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL bp_drain: got %0d responses want 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got_q[i].data !== exp_q[i].data || got_q[i].tag !== exp_q[i].tag) begin
          n_fail++;
          $display("FAIL bp_resp[%0d]: got %h/%h want %h/%h", i, got_q[i].data, got_q[i].tag,
                   exp_q[i].data, exp_q[i].tag);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    got_q.delete();
    bus.resp_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_req();
      bus.req_vld = 1'b1;
      step();
    end
    bus.req_vld = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (bus.resp_vld !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resp_vld: got %b want 0", bus.resp_vld); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req_rdy: got %b want 0", bus.req_rdy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
    repeat (15) step();
    n_checks += 2;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_stale: got %0d responses want 0", got_q.size()); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle_busy: got %b want 0", busy); end
    rand_req();
    bus.req_vld = 1'b1;
    step();
    bus.req_vld = 1'b0;
    drain(1, 20);
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL rst_mid_new: got %0d responses want 1", got_q.size());
    end else begin
      n_checks += 2;
      if (got_q[0].data !== exp_q[0].data || got_q[0].tag !== exp_q[0].tag) begin
        n_fail++;
        $display("FAIL rst_mid_new_data: got %h/%h want %h/%h", got_q[0].data, got_q[0].tag,
                 exp_q[0].data, exp_q[0].tag);
      end
      if (got_q[0].cyc - exp_q[0].cyc != MulLat + 2) begin
        n_fail++; $display("FAIL rst_mid_new_latency: got %0d want %0d", got_q[0].cyc - exp_q[0].cyc, MulLat + 2);
      end
    end
  endtask

`ifdef MUL_ISSUE_CTRL_FLUSH_EN
  task automatic test_flush();
    int n_sent;
    exp_q.delete();
    got_q.delete();
    bus.resp_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin rand_req(); bus.req_vld = 1'b1; step(); end
    bus.req_vld = 1'b0;
    repeat (10) step();
    for (int k = 0; k < 2; k++) begin rand_req(); bus.req_vld = 1'b1; step(); end
    bus.req_vld = 1'b0;
    step();
    flush = 1'b1;
    rand_req();
    bus.req_vld = 1'b1;
    #1;
    n_checks++;
    if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_req_rdy: got %b want 0", bus.req_rdy); end
    step();
    flush = 1'b0;
    bus.req_vld = 1'b0;
    n_checks += 2;
    if (bus.resp_vld !== 1'b0) begin n_fail++; $display("FAIL flush_resp_vld: got %b want 0", bus.resp_vld); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    exp_q.delete();
    got_q.delete();
    bus.resp_rdy = 1'b1;
    rand_req();
    bus.req_vld = 1'b1;
    step();
    bus.req_vld = 1'b0;
    drain(1, 20);
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL flush_new: got %0d responses want 1", got_q.size());
    end else begin
      n_checks += 2;
      if (got_q[0].data !== exp_q[0].data) begin
        n_fail++; $display("FAIL flush_new_data: got %h want %h", got_q[0].data, exp_q[0].data);
      end
      if (got_q[0].cyc - exp_q[0].cyc != MulLat + 2) begin
        n_fail++; $display("FAIL flush_new_latency: got %0d want %0d", got_q[0].cyc - exp_q[0].cyc, MulLat + 2);
      end
    end
    exp_q.delete();
    got_q.delete();
    bus.resp_rdy = 1'b0;
    n_sent = 0;
    rand_req();
    bus.req_vld = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (exp_q.size() > n_sent) begin n_sent = exp_q.size(); rand_req(); end
    end
    bus.req_vld = 1'b0;
    n_checks++;
    if (exp_q.size() != 8) begin n_fail++; $display("FAIL flush_credits: got %0d accepts want 8", exp_q.size()); end
    bus.resp_rdy = 1'b1;
    drain(8, 30);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_vld = 1'b0;
    bus.req_op = 2'd0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_tag = '0;
    bus.resp_rdy = 1'b0;
    #2;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef MUL_ISSUE_CTRL_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
